// File: rtl/hamming_scan_ctrl.sv
// Standalone min/max Hamming-distance sequencer on the shared data memory.
// Loads N 16-bit operands, scans all pairs j<k, and writes the results back.
module hamming_scan_ctrl #(
    parameter int N_WORDS  = 32,
    parameter int ADDR_W   = 8,
    parameter int MIN_ADDR = 64,
    parameter int MAX_ADDR = 65
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [4:0]        min_dist,
    output logic [4:0]        max_dist,
    output logic [4:0]        min_j,
    output logic [4:0]        min_k,
    output logic [4:0]        max_j,
    output logic [4:0]        max_k
);

    typedef enum logic [2:0] {
        IDLE, LOAD, LOAD_DRAIN, SCAN,
        SCAN_DRAIN, WR_MIN, WR_MAX, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 * N_WORDS - 1);
    localparam logic [ADDR_W-1:0] MIN_A     = ADDR_W'(MIN_ADDR);
    localparam logic [ADDR_W-1:0] MAX_A     = ADDR_W'(MAX_ADDR);
    localparam logic [4:0]        K_LAST    = 5'(N_WORDS - 1);
    localparam logic [4:0]        J_LAST    = 5'(N_WORDS - 2);

    state_t            state;
    logic              armed;
    logic [31:0][15:0] buffer;
    logic              rvalid;
    logic [5:0]        raddr;
    logic [4:0]        j, k;
    logic [4:0]        pj, pk;
    logic [4:0]        dist_q;
    logic              dv;

    logic [4:0] dist_c;
    logic       upd_min, upd_max;
    logic [4:0] min_nxt;
    logic       busy, abort;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    assign dist_c  = popcount(buffer[j] ^ buffer[k]);
    assign upd_min = dv && (dist_q < min_dist);
    assign upd_max = dv && (dist_q > max_dist);
    assign min_nxt = upd_min ? dist_q : min_dist;
    assign busy    = (state != IDLE) && (state != DONE);
    assign abort   = start && busy;

    // Read data lags its address by one cycle; rvalid/raddr track that.
    always_ff @(posedge clk) begin
        if (rvalid && !raddr[0]) buffer[raddr[5:1]][15:8] <= mem_rdata;
        if (rvalid && raddr[0])  buffer[raddr[5:1]][7:0]  <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            min_dist  <= 5'd16;
            max_dist  <= 5'd0;
            min_j     <= 5'd0;
            min_k     <= 5'd0;
            max_j     <= 5'd0;
            max_k     <= 5'd0;
            rvalid    <= 1'b0;
            raddr     <= 6'd0;
            j         <= 5'd0;
            k         <= 5'd0;
            pj        <= 5'd0;
            pk        <= 5'd0;
            dist_q    <= 5'd0;
            dv        <= 1'b0;
        end else begin
            rvalid <= mem_rd;
            raddr  <= mem_addr[5:0];
            dv     <= 1'b0;
            mem_wr <= 1'b0;
            if (upd_min) begin
                min_dist <= dist_q;
                min_j    <= pj;
                min_k    <= pk;
            end
            if (upd_max) begin
                max_dist <= dist_q;
                max_j    <= pj;
                max_k    <= pk;
            end
            if (abort) begin
                state    <= IDLE;
                armed    <= 1'b1;
                mem_rd   <= 1'b0;
                mem_addr <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            armed    <= 1'b0;
                            state    <= LOAD;
                            mem_rd   <= 1'b1;
                            mem_addr <= '0;
                            min_dist <= 5'd16;
                            max_dist <= 5'd0;
                            min_j    <= 5'd0;
                            min_k    <= 5'd1;
                            max_j    <= 5'd0;
                            max_k    <= 5'd1;
                        end
                    end
                    LOAD: begin
                        if (mem_addr == LAST_ADDR) begin
                            state    <= LOAD_DRAIN;
                            mem_rd   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    LOAD_DRAIN: begin
                        state <= SCAN;
                        j     <= 5'd0;
                        k     <= 5'd1;
                    end
                    SCAN: begin
                        dv     <= 1'b1;
                        dist_q <= dist_c;
                        pj     <= j;
                        pk     <= k;
                        if (k == K_LAST) begin
                            if (j == J_LAST) begin
                                state <= SCAN_DRAIN;
                            end else begin
                                j <= j + 5'd1;
                                k <= j + 5'd2;
                            end
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                    // Final pair resolves on this edge, so write its outcome.
                    SCAN_DRAIN: begin
                        state     <= WR_MIN;
                        mem_wr    <= 1'b1;
                        mem_addr  <= MIN_A;
                        mem_wdata <= {3'b000, min_nxt};
                    end
                    WR_MIN: begin
                        state     <= WR_MAX;
                        mem_wr    <= 1'b1;
                        mem_addr  <= MAX_A;
                        mem_wdata <= {3'b000, max_dist};
                    end
                    WR_MAX: begin
                        state    <= DONE;
                        done     <= 1'b1;
                        mem_addr <= '0;
                    end
                    DONE: begin
                        if (start) begin
                            state <= IDLE;
                            done  <= 1'b0;
                            armed <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
